fetch_queue: RTL and testbench

- Decoupling instruction queue between the instruction-fetch stage and the decode stage of the pipelined MIPS core.
- Each cycle, fetch pushes one {PC+4, instruction} pair; decode pops pairs under a valid/ready handshake.
- Drives the fetch stage's PCWrite so the PC freezes while the queue is full.
- On a taken branch/jump, flush discards all queued wrong-path entries.

---
 rtl/fetch_queue.sv | 133 +++++++++++++
 tb/tb_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling instruction queue between the fetch and decode
// stages of the pipelined MIPS core. Fetch pushes one {PC+4, instruction}
// pair per cycle, decode pops pairs under a valid/ready handshake. The
// queue drives the fetch stage's PCWrite so the PC freezes while the
// queue is full. A flush, raised on a taken branch/jump, discards every
// queued wrong-path entry.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let an incoming pair
// reach decode in the same cycle when the queue is empty. Left undefined,
// decode outputs come only from registered state (one-cycle latency).
//
// Ports:
//   clk                rising-edge clock
//   reset              asynchronous active-low reset
//   flush              discard all entries and the same-cycle push/pop
//   fetch_valid        fetch presents a valid pair this cycle
//   fetch_instruction  instruction from program memory
//   fetch_pc_4         PC+4 of that instruction
//   pc_write           to fetch PCWrite; PC may advance
//   decode_ready       decode accepts the head entry this cycle
//   decode_valid       head entry valid
//   decode_instruction head instruction, NOP when not valid
//   decode_pc_4        head PC+4, 0 when not valid
//   count              current occupancy, 0..DEPTH

module fetch_queue #(
   parameter int               NBits = 32,
   parameter int               DEPTH = 4,
   parameter logic [NBits-1:0] NOP   = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       fetch_valid,
   input  logic [NBits-1:0]           fetch_instruction,
   input  logic [NBits-1:0]           fetch_pc_4,
   output logic                       pc_write,
   input  logic                       decode_ready,
   output logic                       decode_valid,
   output logic [NBits-1:0]           decode_instruction,
   output logic [NBits-1:0]           decode_pc_4,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PtrW = $clog2(DEPTH);
   localparam int CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

   logic [NBits-1:0] mem_instr [DEPTH];
   logic [NBits-1:0] mem_pc_4  [DEPTH];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             bypass_show;
   logic             bypass_take;

   assign full  = (count == FullCount);
   assign empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
   // An empty queue forwards the incoming pair straight to decode; if
   // decode takes it in the same cycle it never occupies a slot.
   assign bypass_show = empty & fetch_valid & ~flush;
   assign bypass_take = bypass_show & decode_ready;
`else
   assign bypass_show = 1'b0;
   assign bypass_take = 1'b0;
`endif

   // Push is refused when full even if a pop happens this cycle: the
   // fetch stage sees pc_write=0 and re-presents the same PC next cycle.
   assign push = fetch_valid & ~full & ~flush & ~bypass_take;

   // Pop only counts stored entries; a bypassed pair is not in storage.
   assign pop  = decode_ready & ~empty & ~flush;

   // Flush forces pc_write high so the PC can load the branch target
   // in the flush cycle even if the queue was full.
   assign pc_write = ~full | flush;

   // Show-ahead head entry. Without bypass this depends only on
   // registered state.
   always_comb begin
      decode_valid       = 1'b0;
      decode_instruction = NOP;
      decode_pc_4        = '0;
      if (!empty) begin
         decode_valid       = 1'b1;
         decode_instruction = mem_instr[rd_ptr];
         decode_pc_4        = mem_pc_4[rd_ptr];
      end else if (bypass_show) begin
         decode_valid       = 1'b1;
         decode_instruction = fetch_instruction;
         decode_pc_4        = fetch_pc_4;
      end
   end

   // Pointers and occupancy. Flush takes priority over push and pop,
   // cancelling both. Pointers wrap naturally since DEPTH is a power
   // of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PtrW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PtrW'(1);
         end
         count <= count + CntW'(push) - CntW'(pop);
      end
   end

   // Storage carries no reset; its contents only matter once count
   // says an entry is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= fetch_instruction;
         mem_pc_4[wr_ptr]  <= fetch_pc_4;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue with the
// default parameters (NBits=32, DEPTH=4, NOP=0). Inputs change 1 time unit
// after the rising edge; outputs are sampled after they settle, away
// from the edge.

module tb_fetch_queue;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        fetchValid;
   logic [31:0] fetchInstruction;
   logic [31:0] fetchPc4;
   logic        pcWrite;
   logic        decodeReady;
   logic        decodeValid;
   logic [31:0] decodeInstruction;
   logic [31:0] decodePc4;
   logic [2:0]  count;

   int testsRun;
   int testsFailed;

   fetch_queue #(
      .NBits(32),
      .DEPTH(4),
      .NOP(32'h0000_0000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .fetch_valid(fetchValid),
      .fetch_instruction(fetchInstruction),
      .fetch_pc_4(fetchPc4),
      .pc_write(pcWrite),
      .decode_ready(decodeReady),
      .decode_valid(decodeValid),
      .decode_instruction(decodeInstruction),
      .decode_pc_4(decodePc4),
      .count(count)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drives all queue inputs at once.
   task automatic applyStimulus(input logic fv, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic rdy,
                                input logic fl);
      fetchValid       = fv;
      fetchInstruction = instr;
      fetchPc4         = pc4;
      decodeReady      = rdy;
      flush            = fl;
   endtask

   // Advances one rising edge and lets outputs settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wrap-around vectors: {fetch_valid, decode_ready} per cycle.
   logic [1:0]  wrapOps [13];
   logic [31:0] model [$];
   int          pushIdx;

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      wrapOps = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10,
                  2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};

      // Reset held low with random inputs, across a clock edge.
      reset = 1'b0;
      applyStimulus(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      #3;
      checkOutput("rst_count", 64'(count), 64'd0);
      checkOutput("rst_valid", 64'(decodeValid), 64'd0);
      checkOutput("rst_instr", 64'(decodeInstruction), 64'h0);
      checkOutput("rst_pcw", 64'(pcWrite), 64'd1);
      tick();
      checkOutput("rst_hold_count", 64'(count), 64'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      checkOutput("idle_count", 64'(count), 64'd0);
      checkOutput("idle_valid", 64'(decodeValid), 64'd0);
      checkOutput("idle_pc4", 64'(decodePc4), 64'd0);
      checkOutput("idle_pcw", 64'(pcWrite), 64'd1);

      // Single pass through the queue.
      applyStimulus(1'b1, 32'h2008_0005, 32'h0040_0004, 1'b0, 1'b0);
      #1;
`ifndef FETCH_QUEUE_BYPASS_EN
      checkOutput("single_no_bypass", 64'(decodeValid), 64'd0);
`endif
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput("single_valid", 64'(decodeValid), 64'd1);
      checkOutput("single_instr", 64'(decodeInstruction), 64'h2008_0005);
      checkOutput("single_pc4", 64'(decodePc4), 64'h0040_0004);
      checkOutput("single_count", 64'(count), 64'd1);
      decodeReady = 1'b1;
      tick();
      decodeReady = 1'b0;
      #1;
      checkOutput("single_pop_count", 64'(count), 64'd0);
      checkOutput("single_pop_valid", 64'(decodeValid), 64'd0);
      checkOutput("single_pop_instr", 64'(decodeInstruction), 64'h0);

      // Fill four entries, refuse the fifth.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h1000_0000 + 32'(i), 32'h0040_0100 + 32'(4 * i),
                       1'b0, 1'b0);
         tick();
      end
      checkOutput("fill_count", 64'(count), 64'd4);
      checkOutput("fill_pcw", 64'(pcWrite), 64'd0);
      applyStimulus(1'b1, 32'h1000_0004, 32'h0040_0110, 1'b0, 1'b0);
      tick();
      checkOutput("fill_refuse_count", 64'(count), 64'd4);
      checkOutput("fill_head", 64'(decodeInstruction), 64'h1000_0000);
      // Pop while full: push still refused, pc_write stays 0 this cycle.
      decodeReady = 1'b1;
      #1;
      checkOutput("full_pop_pcw", 64'(pcWrite), 64'd0);
      tick();
      decodeReady = 1'b0;
      #1;
      checkOutput("full_pop_count", 64'(count), 64'd3);
      checkOutput("after_pop_pcw", 64'(pcWrite), 64'd1);
      tick();
      checkOutput("repush_count", 64'(count), 64'd4);
      // Drain: entries 1..4 in push order.
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         #1;
         checkOutput($sformatf("drain_instr%0d", k), 64'(decodeInstruction),
                     64'(32'h1000_0000 + 32'(k)));
         checkOutput($sformatf("drain_pc4%0d", k), 64'(decodePc4),
                     64'(32'h0040_0100 + 32'(4 * k)));
         tick();
      end
      decodeReady = 1'b0;
      #1;
      checkOutput("drain_count", 64'(count), 64'd0);

      // Wrap-around: ten pushes interleaved with pops, FIFO order checked.
      model.delete();
      pushIdx = 0;
      for (int c = 0; c < 13; c++) begin
         applyStimulus(wrapOps[c][1], 32'h2000_0000 + 32'(pushIdx),
                       32'h0040_0200 + 32'(4 * pushIdx), wrapOps[c][0], 1'b0);
         #1;
         checkOutput($sformatf("wrap_count%0d", c), 64'(count), 64'(model.size()));
         if (model.size() != 0) begin
            checkOutput($sformatf("wrap_head%0d", c), 64'(decodeInstruction),
                        64'(model[0]));
         end
         tick();
         if (wrapOps[c][0] && model.size() != 0) begin
            void'(model.pop_front());
         end
         if (wrapOps[c][1]) begin
            model.push_back(32'h2000_0000 + 32'(pushIdx));
            pushIdx++;
         end
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput("wrap_end_count", 64'(count), 64'd0);
      checkOutput("wrap_pushes", 64'(pushIdx), 64'd10);

      // Flush with three entries, push and pop both requested.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h3000_0000 + 32'(i), 32'h0040_0300, 1'b0, 1'b0);
         tick();
      end
      checkOutput("preflush_count", 64'(count), 64'd3);
      applyStimulus(1'b1, 32'h3000_00ff, 32'h0040_03fc, 1'b1, 1'b1);
      #1;
      checkOutput("flush_pcw", 64'(pcWrite), 64'd1);
      tick();
      checkOutput("flush_count", 64'(count), 64'd0);
      checkOutput("flush_valid", 64'(decodeValid), 64'd0);
      tick();
      checkOutput("flush2_count", 64'(count), 64'd0);
      applyStimulus(1'b1, 32'h0800_0010, 32'h0040_1000, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput("postflush_head", 64'(decodeInstruction), 64'h0800_0010);
      checkOutput("postflush_count", 64'(count), 64'd1);

      // Flush while full raises pc_write in the flush cycle.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h4000_0000 + 32'(i), 32'h0040_0400, 1'b0, 1'b0);
         tick();
      end
      checkOutput("full2_pcw", 64'(pcWrite), 64'd0);
      flush = 1'b1;
      #1;
      checkOutput("full_flush_pcw", 64'(pcWrite), 64'd1);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput("full_flush_count", 64'(count), 64'd0);

      // Empty queue with fetch and decode both active.
      applyStimulus(1'b1, 32'h0800_0010, 32'h0040_2000, 1'b1, 1'b0);
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      checkOutput("bypass_valid", 64'(decodeValid), 64'd1);
      checkOutput("bypass_instr", 64'(decodeInstruction), 64'h0800_0010);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput("bypass_count", 64'(count), 64'd0);
`else
      checkOutput("nobypass_valid", 64'(decodeValid), 64'd0);
      checkOutput("nobypass_instr", 64'(decodeInstruction), 64'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput("nobypass_count", 64'(count), 64'd1);
      checkOutput("nobypass_head", 64'(decodeInstruction), 64'h0800_0010);
`endif

      // Asynchronous reset in mid-cycle clears state immediately.
      applyStimulus(1'b1, 32'h5000_0000, 32'h0040_5000, 1'b0, 1'b0);
      tick();
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_rst_count", 64'(count), 64'd0);
      checkOutput("async_rst_valid", 64'(decodeValid), 64'd0);
      checkOutput("async_rst_pcw", 64'(pcWrite), 64'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      checkOutput("post_rst_count", 64'(count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
